// File: rtl/rob_param_pkg.sv
// Shared types for the reorder buffer and its consumers (rename, reservation stations).
// Physical register tag, ROB index and row layouts live here so every stage agrees on widths.
package rob_param_pkg;
  localparam int PREG_W    = 7;
  localparam int ROB_DEPTH = 16;

  typedef logic [PREG_W-1:0]            p_reg;
  typedef logic [$clog2(ROB_DEPTH)-1:0] rob_idx;

  typedef struct packed {
    logic valid;
    logic complete;
    p_reg dst;
    p_reg old_dst;
    logic reg_write;
  } rob_row_struct;

  typedef struct packed {
    logic       busy;
    logic [5:0] opcode;
    p_reg       src1;
    p_reg       src2;
    p_reg       dst;
    rob_idx     ROBNumber;
  } rs_row_struct;
endpackage

// File: rtl/rob_commit_sel.sv
// Picks the in-order retirement prefix starting at head: slot i retires only if slots 0..i all do.
// Purely combinational from registered ROB state; flush suppresses every slot.
module rob_commit_sel #(
  parameter int DEPTH    = 16,
  parameter int COMMIT_W = 2,
  parameter int IW       = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]    valid,
  input  logic [DEPTH-1:0]    complete,
  input  logic [IW-1:0]       head,
  input  logic [IW:0]         count,
  input  logic                flush,
  output logic [COMMIT_W-1:0] commit_valid,
  output logic [2:0]          ret_cnt
);
  localparam int CW = IW + 1;

  logic          run;
  logic [IW-1:0] slot;

  always_comb begin
    commit_valid = '0;
    ret_cnt      = '0;
    run          = !flush;
    slot         = head;
    for (int i = 0; i < COMMIT_W; i++) begin
      slot = head + IW'(i);
      run  = run && valid[slot] && complete[slot] && (CW'(i) < count);
      commit_valid[i] = run;
      ret_cnt = ret_cnt + 3'(run);
    end
  end
endmodule

// File: rtl/rob_param.sv
// Parameterised reorder buffer: in-order allocate at tail, out-of-order complete, in-order retire up to COMMIT_W per cycle.
// Allocation space is judged from registered count, so slots freed by a commit are reusable only the next cycle.
module rob_param
  import rob_param_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int COMMIT_W = 2,
  parameter int NUM_CMPL = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         alloc_valid,
  output logic                         alloc_ready,
  input  logic [PREG_W-1:0]            alloc_dst,
  input  logic [PREG_W-1:0]            alloc_old_dst,
  input  logic                         alloc_reg_write,
  output logic [$clog2(DEPTH)-1:0]     alloc_rob_num,
  input  logic [NUM_CMPL-1:0]          cmpl_valid,
  input  logic [NUM_CMPL*$clog2(DEPTH)-1:0] cmpl_rob_num,
  input  logic                         flush,
  output logic [COMMIT_W-1:0]          commit_valid,
  output logic [COMMIT_W*PREG_W-1:0]   commit_old_dst,
  output logic [COMMIT_W*PREG_W-1:0]   commit_dst,
  output logic [COMMIT_W-1:0]          commit_reg_write,
  output logic [$clog2(DEPTH):0]       count
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  rob_row_struct rows [DEPTH];
  logic [IW-1:0]    head;
  logic [IW-1:0]    tail;
  logic [DEPTH-1:0] valid_vec;
  logic [DEPTH-1:0] cmpl_vec;
  logic [2:0]       ret_cnt;
  logic             alloc_fire;
  logic [IW-1:0]    slot;

  assign alloc_ready   = (count < CW'(DEPTH)) && !flush;
  assign alloc_fire    = alloc_valid && alloc_ready;
  assign alloc_rob_num = tail;

  always_comb begin
    valid_vec = '0;
    cmpl_vec  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = rows[i].valid;
      cmpl_vec[i]  = rows[i].complete;
    end
  end

  rob_commit_sel #(
    .DEPTH    (DEPTH),
    .COMMIT_W (COMMIT_W),
    .IW       (IW)
  ) u_commit_sel (
    .valid        (valid_vec),
    .complete     (cmpl_vec),
    .head         (head),
    .count        (count),
    .flush        (flush),
    .commit_valid (commit_valid),
    .ret_cnt      (ret_cnt)
  );

  // Payload is driven for every slot; consumers qualify it with commit_valid.
  always_comb begin
    commit_old_dst   = '0;
    commit_dst       = '0;
    commit_reg_write = '0;
    slot             = head;
    for (int i = 0; i < COMMIT_W; i++) begin
      slot = head + IW'(i);
      commit_old_dst[i*PREG_W +: PREG_W] = rows[slot].old_dst;
      commit_dst[i*PREG_W +: PREG_W]     = rows[slot].dst;
      commit_reg_write[i]                = rows[slot].reg_write;
    end
  end

  // Completion is applied before retirement clears and allocation writes, so those win on overlap.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) rows[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int p = 0; p < NUM_CMPL; p++) begin
        if (cmpl_valid[p] && rows[cmpl_rob_num[p*IW +: IW]].valid)
          rows[cmpl_rob_num[p*IW +: IW]].complete <= 1'b1;
      end
      for (int i = 0; i < COMMIT_W; i++) begin
        if (commit_valid[i]) rows[head + IW'(i)] <= '0;
      end
      if (alloc_fire) begin
        rows[tail] <= '{valid: 1'b1, complete: 1'b0, dst: alloc_dst,
                        old_dst: alloc_old_dst, reg_write: alloc_reg_write};
      end
      head  <= head + IW'(ret_cnt);
      tail  <= tail + IW'(alloc_fire);
      count <= count + CW'(alloc_fire) - CW'(ret_cnt);
    end
  end
endmodule

// File: tb/tb_rob_param.sv
// Bench for rob_param (DEPTH=16, COMMIT_W=2, NUM_CMPL=3): directed scenarios then random traffic,
// every cycle compared against an in-order queue model of the ROB.
module tb_rob_param;
  logic        clk = 1'b0;
  logic        reset;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [6:0]  alloc_dst;
  logic [6:0]  alloc_old_dst;
  logic        alloc_reg_write;
  logic [3:0]  alloc_rob_num;
  logic [2:0]  cmpl_valid;
  logic [11:0] cmpl_rob_num;
  logic        flush;
  logic [1:0]  commit_valid;
  logic [13:0] commit_old_dst;
  logic [13:0] commit_dst;
  logic [1:0]  commit_reg_write;
  logic [4:0]  count;

  rob_param #(.DEPTH(16), .COMMIT_W(2), .NUM_CMPL(3)) dut (
    .clk              (clk),
    .reset            (reset),
    .alloc_valid      (alloc_valid),
    .alloc_ready      (alloc_ready),
    .alloc_dst        (alloc_dst),
    .alloc_old_dst    (alloc_old_dst),
    .alloc_reg_write  (alloc_reg_write),
    .alloc_rob_num    (alloc_rob_num),
    .cmpl_valid       (cmpl_valid),
    .cmpl_rob_num     (cmpl_rob_num),
    .flush            (flush),
    .commit_valid     (commit_valid),
    .commit_old_dst   (commit_old_dst),
    .commit_dst       (commit_dst),
    .commit_reg_write (commit_reg_write),
    .count            (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int dst;
    int old;
    bit rw;
    bit done;
  } ent_t;

  ent_t q[$];
  int   m_tail;
  int   checks;
  int   errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; alloc_valid = 1'b0; cmpl_valid = '0; flush = 1'b0;
    alloc_dst = '0; alloc_old_dst = '0; alloc_reg_write = 1'b0; cmpl_rob_num = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    q.delete();
    m_tail = 0;
  endtask

  // One clock: drive, check outputs mid-cycle against the model, then advance the model at the edge.
  task automatic cyc(input bit av, input bit rw, input bit [2:0] cv,
                     input int c0, input int c1, input int c2, input bit fl);
    int  n;
    bit  fire;
    int  cidx[3];
    cidx = '{c0, c1, c2};
    alloc_valid     = av;
    alloc_reg_write = rw;
    alloc_dst       = 7'($urandom);
    alloc_old_dst   = 7'($urandom);
    cmpl_valid      = cv;
    cmpl_rob_num    = {4'(c2), 4'(c1), 4'(c0)};
    flush           = fl;
    @(negedge clk);
    n = 0;
    if (!fl) while (n < 2 && n < q.size() && q[n].done) n++;
    chk("alloc_ready", 32'(alloc_ready), 32'(q.size() < 16 && !fl));
    chk("alloc_rob_num", 32'(alloc_rob_num), m_tail);
    chk("count", 32'(count), q.size());
    chk("commit_valid", 32'(commit_valid), (1 << n) - 1);
    for (int s = 0; s < n; s++) begin
      chk("commit_dst", 32'(commit_dst[s*7 +: 7]), q[s].dst);
      chk("commit_old_dst", 32'(commit_old_dst[s*7 +: 7]), q[s].old);
      chk("commit_reg_write", 32'(commit_reg_write[s]), 32'(q[s].rw));
    end
    fire = av && (q.size() < 16) && !fl;
    @(posedge clk);
    if (fl) begin
      q.delete();
      m_tail = 0;
    end else begin
      for (int p = 0; p < 3; p++) begin
        if (cv[p]) begin
          for (int k = 0; k < q.size(); k++) begin
            if (q[k].idx == cidx[p]) begin
              ent_t e;
              e = q[k];
              e.done = 1'b1;
              q[k] = e;
            end
          end
        end
      end
      repeat (n) void'(q.pop_front());
      if (fire) begin
        q.push_back('{idx: m_tail, dst: int'(alloc_dst), old: int'(alloc_old_dst), rw: rw, done: 1'b0});
        m_tail = (m_tail + 1) % 16;
      end
    end
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset state, then fill the ROB back-to-back.
    do_reset();
    cyc(0, 1, 3'b000, 0, 0, 0, 0);
    repeat (16) cyc(1, 1, 3'b000, 0, 0, 0, 0);
    chk("full_count", 32'(count), 16);
    chk("full_alloc_ready", 32'(alloc_ready), 0);

    // Full ROB: complete the head while alloc_valid is held; refill lands at wrapped index 0.
    cyc(1, 1, 3'b001, 0, 0, 0, 0);
    cyc(1, 1, 3'b000, 0, 0, 0, 0);
    cyc(1, 1, 3'b000, 0, 0, 0, 0);
    chk("wrap_count", 32'(count), 16);
    cyc(0, 1, 3'b000, 0, 0, 0, 0);

    // Out-of-order completion: #1 then #0, both retire together.
    do_reset();
    repeat (3) cyc(1, 1, 3'b000, 0, 0, 0, 0);
    cyc(0, 1, 3'b001, 1, 0, 0, 0);
    cyc(0, 1, 3'b001, 0, 0, 0, 0);
    cyc(0, 1, 3'b000, 0, 0, 0, 0);
    chk("ooo_count", 32'(count), 1);
    cyc(0, 1, 3'b000, 0, 0, 0, 0);

    // Flush with partially completed entries.
    do_reset();
    repeat (5) cyc(1, 1, 3'b000, 0, 0, 0, 0);
    cyc(0, 1, 3'b011, 1, 2, 0, 0);
    cyc(1, 1, 3'b000, 0, 0, 0, 1);
    cyc(0, 1, 3'b000, 0, 0, 0, 0);
    chk("flush_count", 32'(count), 0);

    // Triple completion to one index, completion to an unallocated index.
    do_reset();
    repeat (6) cyc(1, 1, 3'b000, 0, 0, 0, 0);
    cyc(0, 1, 3'b111, 4, 4, 4, 0);
    cyc(0, 1, 3'b111, 9, 9, 9, 0);
    cyc(0, 1, 3'b000, 0, 0, 0, 0);
    cyc(0, 1, 3'b111, 0, 1, 2, 0);
    cyc(0, 1, 3'b001, 3, 0, 0, 0);
    repeat (4) cyc(0, 1, 3'b000, 0, 0, 0, 0);
    chk("drain_count", 32'(count), 1);

    // Non-writing instruction; completion in its allocation cycle is ignored.
    do_reset();
    cyc(1, 0, 3'b001, 0, 0, 0, 0);
    cyc(0, 1, 3'b000, 0, 0, 0, 0);
    cyc(0, 1, 3'b001, 0, 0, 0, 0);
    cyc(0, 1, 3'b000, 0, 0, 0, 0);

    // Random traffic, completions biased toward live entries.
    do_reset();
    for (int t = 0; t < 600; t++) begin
      int ci[3];
      for (int p = 0; p < 3; p++) begin
        if (q.size() > 0 && $urandom_range(0, 3) != 0)
          ci[p] = q[$urandom_range(0, q.size() - 1)].idx;
        else
          ci[p] = $urandom_range(0, 15);
      end
      cyc($urandom_range(0, 9) < 7, 1'($urandom), 3'($urandom), ci[0], ci[1], ci[2],
          $urandom_range(0, 49) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rob_param.md
ROB_PARAM -- requirements
Module: rob_param

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning ROB entries; power of two, 4..64.
REQ-002 SHALL have parameter COMMIT_W, default 2, meaning max retirements per cycle, 1..4.
REQ-003 SHALL have parameter NUM_CMPL, default 3, meaning completion ports (FU1, FU2, FU3/mem).
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port alloc_valid, input, 1, rename stage offers one instruction.
REQ-007 SHALL have port alloc_ready, output, 1, ROB can accept an entry this cycle.
REQ-008 SHALL have port alloc_dst, input, 7 (p_reg), new physical destination.
REQ-009 SHALL have port alloc_old_dst, input, 7 (p_reg), previous mapping of the architectural destination.
REQ-010 SHALL have port alloc_reg_write, input, 1, instruction writes a register.
REQ-011 SHALL have port alloc_rob_num, output, log2(DEPTH), index assigned to the offered instruction (current tail).
REQ-012 SHALL have port cmpl_valid, input, NUM_CMPL, per-port completion strobe.
REQ-013 SHALL have port cmpl_rob_num, input, NUM_CMPL x log2(DEPTH), completing entry index.
REQ-014 SHALL have port flush, input, 1, discard all entries (mispredict/exception).
REQ-015 SHALL have port commit_valid, output, COMMIT_W, slot i retires this cycle.
REQ-016 SHALL have port commit_old_dst, output, COMMIT_W x 7, register returned to free list per slot.
REQ-017 SHALL have port commit_dst, output, COMMIT_W x 7, committed mapping per slot (retirement RAT update).
REQ-018 SHALL have port commit_reg_write, output, COMMIT_W, slot writes a register; free-list return only when set.
REQ-019 SHALL have port count, output, log2(DEPTH)+1, occupied entries.

Function
REQ-020 SHALL keep circular storage with head, tail, count; indices wrap modulo DEPTH.
REQ-021 SHALL drive alloc_ready = (count < DEPTH) and not flush, computed from registered count (no same-cycle reuse of slots freed by commit).
REQ-022 SHALL, on alloc_valid && alloc_ready, write entry[tail] with valid=1, complete=0, dst, old_dst, reg_write, and advance tail by 1.
REQ-023 SHALL, per cmpl port with cmpl_valid set and target entry valid, set entry.complete=1; completion to an invalid entry is ignored; duplicate completions on multiple ports in one cycle are harmless.
REQ-024 SHALL assert commit_valid[i] combinationally from registered state iff entries head..head+i are all valid and complete (contiguous in-order prefix, i < count).
REQ-025 SHALL, at the edge, clear retired entries and advance head by the number of asserted commit_valid bits.
REQ-026 SHALL update count = count + alloc_fire - retired each cycle; simultaneous alloc and commit both take effect.
REQ-027 SHALL give minimum latency: completion at edge N visible as commit_valid in cycle after edge N; allocation at edge N retires no earlier than one cycle after its completion.
REQ-028 SHALL force commit_valid to zero while flush is high; at the edge, flush clears all valid/complete bits, head=tail=0, count=0, and overrides alloc, completion and commit.
REQ-029 SHALL treat a completion arriving in the same cycle as its entry's allocation as ignored (entry not yet valid).

Reset
REQ-030 SHALL, on reset high at a rising edge, clear all valid/complete bits, head=tail=count=0, regardless of in-flight operation.
REQ-031 SHALL present after reset: alloc_ready=1, alloc_rob_num=0, commit_valid=0, count=0; commit_*dst and commit_reg_write don't-care while commit_valid is low.

Structure
REQ-032 SHALL take p_reg, rob_row_struct (extended with RegWrite) and new constant ROB_DEPTH plus typedef rob_idx from the shared Types package; rs_row_struct.ROBNumber shall use rob_idx.
REQ-033 SHALL be a single module; the commit-prefix logic is natural as sub-module rob_commit_sel.

Verification
REQ-034 SHALL cover: reset, allocate 16 entries back-to-back -> alloc_rob_num 0..15, count=16, alloc_ready=0 in cycle after 16th.
REQ-035 SHALL cover: allocate 3, complete ROB#1 then ROB#0 -> no commit after #1; after #0, commit_valid=2'b11 with old_dst of #0,#1; count 3->1.
REQ-036 SHALL cover: full ROB, complete head, hold alloc_valid -> commit in cycle C, alloc accepted cycle C+1 at wrapped index 0, count stays 16.
REQ-037 SHALL cover: 5 entries with 2 complete, assert flush -> commit_valid=0 that cycle, next cycle count=0, alloc_rob_num=0.
REQ-038 SHALL cover: completion on all three ports to same index 4 plus one to invalid index 9 -> entry 4 complete only, no spurious commit.
REQ-039 SHALL cover: alloc_reg_write=0 entry retires -> commit_valid=1, commit_reg_write=0.
